// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between uart_rx/uart_tx and a combinational ALU: collects A, B and opcode,
// hands the ALU result to the transmitter. Optional inter-byte timeout: UART_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_overrun,
    output logic               o_timeout
);

    // state   | meaning
    // WAIT_A  | idle, next byte is operand A
    // WAIT_B  | next byte is operand B
    // WAIT_OP | next byte is the opcode
    // EXEC    | one cycle: ALU result captured, transmit started
    // WAIT_TX | waiting for the transmitter to finish
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] alu_a_q, alu_a_d;
    logic [NB_DATA-1:0] alu_b_q, alu_b_d;
    logic [NB_OP-1:0]   alu_op_q, alu_op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;
    logic               expire_w;

    // Upper byte bits carry no opcode information.
    logic rx_hi_unused;
    assign rx_hi_unused = ^i_rx_data[NB_DATA-1:NB_OP];

`ifdef UART_CTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_partial_w;

    assign in_partial_w = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign expire_w     = in_partial_w && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_rx_done || !in_partial_w || expire_w) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES == 0);
    assign expire_w       = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = WAIT_OP;
                end else if (expire_w) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    alu_op_d = i_rx_data[NB_OP-1:0];
                    state_d  = EXEC;
                end else if (expire_w) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end
            end
            EXEC: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                overrun_d  = i_rx_done;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                // A byte arriving here is dropped even if tx_done frees us this cycle.
                overrun_d = i_rx_done;
                if (i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
        busy_d = (state_d != WAIT_A);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_overrun  = overrun_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a small add/sub ALU stub; timeout scenario depends
// on UART_CTRL_TIMEOUT_EN.
module tb_uart_alu_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       overrun;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    uart_alu_ctrl #(
        .NB_DATA       (8),
        .NB_OP         (6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .i_alu_result(alu_result),
        .i_tx_done   (tx_done),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_busy      (busy),
        .o_overrun   (overrun),
        .o_timeout   (timeout)
    );

    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        checks++;
        if (alu_a !== 8'h11) begin
            failures++; $display("FAIL reset_pre_a got %h exp 11", alu_a);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op, tx_data} !== 30'h0) begin
            failures++; $display("FAIL reset_regs got %h exp 0", {alu_a, alu_b, alu_op, tx_data});
        end
        checks++;
        if ({tx_start, busy, overrun, timeout} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got %b exp 0000", {tx_start, busy, overrun, timeout});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        send_byte(8'h05);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL basic_busy_after_a got %b exp 1", busy);
        end
        send_byte(8'h03);
        send_byte(8'h20);
        checks++;
        if (alu_op !== 6'h20) begin
            failures++; $display("FAIL basic_op got %h exp 20", alu_op);
        end
        checks++;
        if (tx_start !== 1'b0) begin
            failures++; $display("FAIL basic_start_early got %b exp 0", tx_start);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h08) begin
            failures++; $display("FAIL basic_start got start=%b data=%h exp 1/08", tx_start, tx_data);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL basic_start_width got start=%b busy=%b exp 0/1", tx_start, busy);
        end
        pulse_tx_done();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL basic_idle got %b exp 0", busy);
        end
    endtask

    task automatic test_overrun_and_op_mask();
        send_byte(8'h07);
        send_byte(8'h02);
        send_byte(8'h20);
        @(posedge clk); #1;
        checks++;
        if (tx_data !== 8'h09) begin
            failures++; $display("FAIL ovr_first_result got %h exp 09", tx_data);
        end
        send_byte(8'hAA);
        checks++;
        if (overrun !== 1'b1 || alu_a !== 8'h07 || busy !== 1'b1) begin
            failures++; $display("FAIL ovr_pulse got ovr=%b a=%h busy=%b exp 1/07/1", overrun, alu_a, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (overrun !== 1'b0) begin
            failures++; $display("FAIL ovr_width got %b exp 0", overrun);
        end
        pulse_tx_done();
        send_byte(8'h10);
        send_byte(8'h04);
        send_byte(8'hE2);
        checks++;
        if (alu_op !== 6'h22) begin
            failures++; $display("FAIL op_mask got %h exp 22", alu_op);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h0C) begin
            failures++; $display("FAIL ovr_next_frame got start=%b data=%h exp 1/0c", tx_start, tx_data);
        end
        pulse_tx_done();
    endtask

    task automatic test_timeout();
        int seen;
        seen = 0;
        send_byte(8'h33);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (timeout === 1'b1) seen++;
        end
`ifdef UART_CTRL_TIMEOUT_EN
        checks++;
        if (seen !== 1 || busy !== 1'b0 || alu_a !== 8'h33) begin
            failures++; $display("FAIL timeout got pulses=%0d busy=%b a=%h exp 1/0/33", seen, busy, alu_a);
        end
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h20);
        @(posedge clk); #1;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h02) begin
            failures++; $display("FAIL timeout_next got start=%b data=%h exp 1/02", tx_start, tx_data);
        end
`else
        checks++;
        if (seen !== 0 || busy !== 1'b1) begin
            failures++; $display("FAIL no_timeout got pulses=%0d busy=%b exp 0/1", seen, busy);
        end
        send_byte(8'h01);
        send_byte(8'h20);
        @(posedge clk); #1;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h34) begin
            failures++; $display("FAIL no_timeout_frame got start=%b data=%h exp 1/34", tx_start, tx_data);
        end
`endif
        pulse_tx_done();
    endtask

    task automatic test_back_to_back();
        send_byte(8'h03);
        pulse_tx_done();
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL b2b_txdone_ignored got busy=%b exp 1", busy);
        end
        send_byte(8'h04);
        send_byte(8'h20);
        @(posedge clk); #1;
        checks++;
        if (tx_data !== 8'h07) begin
            failures++; $display("FAIL b2b_first got %h exp 07", tx_data);
        end
        @(posedge clk); #1;
        rx_data = 8'h55;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        tx_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b1 || alu_a !== 8'h03) begin
            failures++; $display("FAIL b2b_collide got busy=%b ovr=%b a=%h exp 0/1/03", busy, overrun, alu_a);
        end
        send_byte(8'h09);
        checks++;
        if (alu_a !== 8'h09 || busy !== 1'b1) begin
            failures++; $display("FAIL b2b_next_a got a=%h busy=%b exp 09/1", alu_a, busy);
        end
        send_byte(8'h01);
        send_byte(8'h22);
        @(posedge clk); #1;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h08) begin
            failures++; $display("FAIL b2b_second got start=%b data=%h exp 1/08", tx_start, tx_data);
        end
        pulse_tx_done();
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic_frame();
        test_overrun_and_op_mask();
        test_timeout();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
